// File: rtl/program_loader_memory.sv
// Unified 20-bit program/data memory that holds the core in reset while the image loads.
// Optional zeroing phase before load is compiled in with `LOADER_CLEAR_EN.
//
// state | meaning
// CLEAR | step ptr over every word writing 0 (LOADER_CLEAR_EN only)
// LOAD  | accept load words at ptr until LoadLast or the top word
// RUN   | core out of reset, memory serves Daddress/Dout/W
module program_loader_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 20
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  LoadValid,
  input  logic [DATA_WIDTH-1:0] LoadData,
  input  logic                  LoadLast,
  output logic                  LoadReady,
  output logic [ADDR_WIDTH:0]   LoadCount,
  output logic                  CpuReset,
  input  logic [19:0]           Daddress,
  input  logic [DATA_WIDTH-1:0] Dout,
  input  logic                  W,
  output logic [DATA_WIDTH-1:0] DataIn
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

`ifdef LOADER_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = LOAD;
`endif

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    in_range;
  logic                    xfer;
  logic                    last_word;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  assign in_range  = (Daddress[19:ADDR_WIDTH] == '0);
  assign xfer      = (state == LOAD) && LoadValid && LoadReady;
  // The top word ends the image even without LoadLast, so the pointer never wraps.
  assign last_word = LoadLast || (&ptr);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = ptr;
    mem_wdata = '0;
    case (state)
`ifdef LOADER_CLEAR_EN
      CLEAR: mem_we = 1'b1;
`endif
      LOAD: begin
        mem_we    = xfer;
        mem_wdata = LoadData;
      end
      RUN: begin
        mem_we    = W && in_range;
        mem_addr  = Daddress[ADDR_WIDTH-1:0];
        mem_wdata = Dout;
      end
      default: mem_we = 1'b0;
    endcase
  end

  // No reset on the array: contents survive Reset and are only zeroed by CLEAR.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= RESET_STATE;
      ptr       <= '0;
      LoadCount <= '0;
      LoadReady <= 1'b0;
      CpuReset  <= 1'b1;
      DataIn    <= '0;
    end else begin
      DataIn <= '0;
      case (state)
`ifdef LOADER_CLEAR_EN
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (&ptr) begin
            state     <= LOAD;
            ptr       <= '0;
            LoadReady <= 1'b1;
          end
        end
`endif
        LOAD: begin
          LoadReady <= 1'b1;
          if (xfer) begin
            ptr       <= ptr + 1'b1;
            LoadCount <= LoadCount + 1'b1;
            if (last_word) begin
              state     <= RUN;
              LoadReady <= 1'b0;
              CpuReset  <= 1'b0;
            end
          end
        end
        RUN: begin
          // Read-first: the array write for this edge lands after this sample.
          DataIn <= in_range ? mem[Daddress[ADDR_WIDTH-1:0]] : '0;
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader_memory.sv
// Directed bench for program_loader_memory at ADDR_WIDTH=4; covers both LOADER_CLEAR_EN builds.
module tb_program_loader_memory;

  logic        Clock;
  logic        Reset;
  logic        LoadValid;
  logic [19:0] LoadData;
  logic        LoadLast;
  logic        LoadReady;
  logic [4:0]  LoadCount;
  logic        CpuReset;
  logic [19:0] Daddress;
  logic [19:0] Dout;
  logic        W;
  logic [19:0] DataIn;

  int n_checks = 0;
  int n_errors = 0;

  program_loader_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(20)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .LoadValid (LoadValid),
    .LoadData  (LoadData),
    .LoadLast  (LoadLast),
    .LoadReady (LoadReady),
    .LoadCount (LoadCount),
    .CpuReset  (CpuReset),
    .Daddress  (Daddress),
    .Dout      (Dout),
    .W         (W),
    .DataIn    (DataIn)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_word(input logic [19:0] d, input logic l);
    LoadValid = 1'b1;
    LoadData  = d;
    LoadLast  = l;
    step();
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [19:0] a, input logic [19:0] exp);
    Daddress = a;
    W        = 1'b0;
    step();
    check(tag, 32'(DataIn), 32'(exp));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!LoadReady && n < 40) begin
      step();
      n++;
    end
    check("ready_wait", 32'(LoadReady), 32'd1);
  endtask

  task automatic async_reset_chk(input string tag);
    #3 Reset = 1'b1;
    #1;
    check({tag, "_cpureset"}, 32'(CpuReset), 32'd1);
    check({tag, "_count"}, 32'(LoadCount), 32'd0);
    check({tag, "_ready"}, 32'(LoadReady), 32'd0);
    check({tag, "_datain"}, 32'(DataIn), 32'd0);
    step();
    Reset = 1'b0;
  endtask

  initial begin
    Reset     = 1'b1;
    LoadValid = 1'b0;
    LoadData  = '0;
    LoadLast  = 1'b0;
    Daddress  = '0;
    Dout      = '0;
    W         = 1'b0;

    #2;
    check("rst_cpureset", 32'(CpuReset), 32'd1);
    check("rst_ready", 32'(LoadReady), 32'd0);
    check("rst_count", 32'(LoadCount), 32'd0);
    check("rst_datain", 32'(DataIn), 32'd0);
    step();
    step();
    Reset = 1'b0;

`ifdef LOADER_CLEAR_EN
    for (int i = 1; i <= 16; i++) begin
      step();
      check("clear_ready", 32'(LoadReady), (i == 16) ? 32'd1 : 32'd0);
      check("clear_cpureset", 32'(CpuReset), 32'd1);
      check("clear_datain", 32'(DataIn), 32'd0);
    end
`else
    step();
    check("noclear_ready", 32'(LoadReady), 32'd1);
`endif

    // Implicit last: 16 zero words without LoadLast; also zero-fills the array.
    for (int i = 0; i < 16; i++) begin
      load_word(20'h00000, 1'b0);
      if (i == 14) begin
        check("impl_15_cpureset", 32'(CpuReset), 32'd1);
        check("impl_15_ready", 32'(LoadReady), 32'd1);
      end
    end
    check("impl_cpureset", 32'(CpuReset), 32'd0);
    check("impl_ready", 32'(LoadReady), 32'd0);
    check("impl_count", 32'(LoadCount), 32'd16);
    LoadValid = 1'b1;
    LoadData  = 20'hABCDE;
    for (int i = 0; i < 3; i++) step();
    LoadValid = 1'b0;
    check("impl_ignore_count", 32'(LoadCount), 32'd16);
    check("impl_ignore_ready", 32'(LoadReady), 32'd0);
    read_chk("impl_rd0", 20'h00000, 20'h00000);
    read_chk("impl_rd15", 20'h0000F, 20'h00000);

    // Basic load with a gap after the first word.
    async_reset_chk("rst_run");
    wait_ready();
    load_word(20'h1A001, 1'b0);
    check("basic_w1_count", 32'(LoadCount), 32'd1);
    check("basic_w1_cpureset", 32'(CpuReset), 32'd1);
    step();
    check("basic_gap_count", 32'(LoadCount), 32'd1);
    load_word(20'h2B002, 1'b0);
    check("basic_w2_cpureset", 32'(CpuReset), 32'd1);
    load_word(20'h30003, 1'b1);
    check("basic_count", 32'(LoadCount), 32'd3);
    check("basic_cpureset", 32'(CpuReset), 32'd0);
    check("basic_ready", 32'(LoadReady), 32'd0);
    read_chk("basic_rd1", 20'h00001, 20'h2B002);
    read_chk("basic_rd5", 20'h00005, 20'h00000);

    // RUN write, read-first on the same edge.
    Daddress = 20'h00002;
    Dout     = 20'hFFFFF;
    W        = 1'b1;
    step();
    check("wr_same_edge", 32'(DataIn), 32'h30003);
    W = 1'b0;
    step();
    check("wr_next_edge", 32'(DataIn), 32'hFFFFF);

    // Out-of-range write is dropped and must not alias onto word 0.
    Daddress = 20'h00010;
    Dout     = 20'h12345;
    W        = 1'b1;
    step();
    check("oor_wr_read", 32'(DataIn), 32'd0);
    W = 1'b0;
    read_chk("oor_rd10", 20'h00010, 20'h00000);
    read_chk("oor_rd0", 20'h00000, 20'h1A001);
    read_chk("oor_rd_high", 20'h80002, 20'h00000);

    // Async reset mid-LOAD after two words, then reload.
    async_reset_chk("rst_run2");
    wait_ready();
    load_word(20'h11111, 1'b0);
    load_word(20'h22222, 1'b0);
    check("mid_count2", 32'(LoadCount), 32'd2);
    async_reset_chk("rst_mid");
    wait_ready();
    check("reload_count0", 32'(LoadCount), 32'd0);
    load_word(20'h0AAAA, 1'b0);
    load_word(20'h0BBBB, 1'b1);
    check("reload_count", 32'(LoadCount), 32'd2);
    check("reload_cpureset", 32'(CpuReset), 32'd0);
    read_chk("reload_rd0", 20'h00000, 20'h0AAAA);
    read_chk("reload_rd1", 20'h00001, 20'h0BBBB);
`ifdef LOADER_CLEAR_EN
    read_chk("reload_rd2", 20'h00002, 20'h00000);
`else
    read_chk("reload_rd2", 20'h00002, 20'hFFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
